// File: rtl/fp_flags_buffer_pkg.sv
// Shared types for FPU exception-flag tracking: flag set layout, the FPU flag
// update record, and sqN / branch-provider types reused from the core.
package fp_flags_buffer_pkg;

    localparam int unsigned SQN_WIDTH = 7;

    localparam int unsigned FLAG_NX = 0;
    localparam int unsigned FLAG_UF = 1;
    localparam int unsigned FLAG_OF = 2;
    localparam int unsigned FLAG_DZ = 3;
    localparam int unsigned FLAG_NV = 4;

    typedef logic [SQN_WIDTH-1:0] SqN;

    typedef struct packed {
        logic taken;
        SqN   sqN;
    } BranchProv;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } FpFlags;

    typedef struct packed {
        logic   valid;
        SqN     sqN;
        FpFlags flags;
    } FpFlagsUpdate;

    // True when a is strictly younger than b in wrap-around sqN order.
    function automatic logic sqn_newer(input SqN a, input SqN b);
        SqN diff;
        diff = a - b;
        return !diff[SQN_WIDTH-1] && (diff != '0);
    endfunction

endpackage

// File: rtl/fp_flags_commit_or.sv
// Commit-side lookup: matches each commit slot against its entry tag and
// ORs the flags of every matching entry into one accumulated set.
module fp_flags_commit_or
    import fp_flags_buffer_pkg::*;
#(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned COMMIT_W = 4,
    parameter int unsigned SQN_W    = 7,
    localparam int unsigned IDX_W   = $clog2(DEPTH),
    localparam int unsigned CW_IDX  = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1
) (
    input  logic [DEPTH-1:0]               ent_valid_i,
    input  logic [DEPTH-1:0][SQN_W-1:0]    ent_tag_i,
    input  FpFlags [DEPTH-1:0]             ent_flags_i,
    input  logic [COMMIT_W-1:0]            com_valid_i,
    input  logic [COMMIT_W-1:0][SQN_W-1:0] com_sqn_i,
    output FpFlags                         acc_o,
    output logic [COMMIT_W-1:0][IDX_W-1:0] clr_idx_o,
    output logic [COMMIT_W-1:0]            clr_valid_o
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        acc_o       = '0;
        clr_idx_o   = '0;
        clr_valid_o = '0;
        idx         = '0;
        for (int unsigned i = 0; i < COMMIT_W; i++) begin
            idx = com_sqn_i[CW_IDX'(i)][IDX_W-1:0];
            clr_idx_o[CW_IDX'(i)] = idx;
            // Non-FP uops land here too; a stale or foreign tag simply misses.
            if (com_valid_i[CW_IDX'(i)] && ent_valid_i[idx]
                && (ent_tag_i[idx] == com_sqn_i[CW_IDX'(i)])) begin
                clr_valid_o[CW_IDX'(i)] = 1'b1;
                acc_o = acc_o | ent_flags_i[idx];
            end
        end
    end

endmodule

// File: rtl/fp_flags_buffer.sv
// Holds per-uop FPU exception flags speculatively until commit, then ORs
// them into the architectural fflags; also serves CSR reads/writes of fflags.
module fp_flags_buffer
    import fp_flags_buffer_pkg::*;
#(
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned COMMIT_W = 4,
    parameter int unsigned SQN_W    = 7
) (
    input  logic                           clk,
    input  logic                           rst,
    input  BranchProv                      IN_branch,
    input  logic                           IN_upd_valid,
    input  logic [SQN_W-1:0]               IN_upd_sqN,
    input  logic [4:0]                     IN_upd_flags,
    input  logic [COMMIT_W-1:0]            IN_com_valid,
    input  logic [COMMIT_W-1:0][SQN_W-1:0] IN_com_sqN,
    input  logic                           IN_csr_we,
    input  logic [4:0]                     IN_csr_wdata,
    output logic [4:0]                     OUT_fflags,
    output logic                           OUT_pending
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned CW_IDX = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

    logic [DEPTH-1:0]            valid_q, valid_d;
    logic [DEPTH-1:0][SQN_W-1:0] tag_q, tag_d;
    FpFlags [DEPTH-1:0]          flags_q, flags_d;
    FpFlags                      fflags_q, fflags_d;
    logic                        pending_q, pending_d;

    FpFlags                         acc;
    logic [COMMIT_W-1:0][IDX_W-1:0] clr_idx;
    logic [COMMIT_W-1:0]            clr_valid;

    logic             upd_en;
    logic [IDX_W-1:0] upd_idx;

    fp_flags_commit_or #(
        .DEPTH    (DEPTH),
        .COMMIT_W (COMMIT_W),
        .SQN_W    (SQN_W)
    ) u_commit_or (
        .ent_valid_i (valid_q),
        .ent_tag_i   (tag_q),
        .ent_flags_i (flags_q),
        .com_valid_i (IN_com_valid),
        .com_sqn_i   (IN_com_sqN),
        .acc_o       (acc),
        .clr_idx_o   (clr_idx),
        .clr_valid_o (clr_valid)
    );

    assign upd_idx = IN_upd_sqN[IDX_W-1:0];
    assign upd_en  = IN_upd_valid && !(IN_branch.taken && sqn_newer(IN_upd_sqN, IN_branch.sqN));

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        flags_d = flags_q;

        for (int unsigned i = 0; i < COMMIT_W; i++) begin
            if (clr_valid[CW_IDX'(i)]) begin
                valid_d[clr_idx[CW_IDX'(i)]] = 1'b0;
            end
        end

        if (IN_branch.taken) begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (valid_q[IDX_W'(e)] && sqn_newer(tag_q[IDX_W'(e)], IN_branch.sqN)) begin
                    valid_d[IDX_W'(e)] = 1'b0;
                end
            end
        end

        // Applied last so a same-index update overrides a commit clear or flush.
        if (upd_en) begin
            valid_d[upd_idx] = 1'b1;
            tag_d[upd_idx]   = IN_upd_sqN;
            flags_d[upd_idx] = IN_upd_flags;
        end

        fflags_d  = (IN_csr_we ? FpFlags'(IN_csr_wdata) : fflags_q) | acc;
        pending_d = |valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            fflags_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            fflags_q  <= fflags_d;
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q   <= tag_d;
        flags_q <= flags_d;
    end

    assign OUT_fflags  = fflags_q;
    assign OUT_pending = pending_q;

endmodule

// File: tb/tb_fp_flags_buffer.sv
// Scoreboard bench for fp_flags_buffer: directed scenarios plus random traffic
// against a sqN-keyed reference model.
module tb_fp_flags_buffer;
    import fp_flags_buffer_pkg::*;

    localparam int unsigned CW = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    BranchProv             br;
    logic                  upd_valid;
    logic [6:0]            upd_sqn;
    logic [4:0]            upd_flags;
    logic [CW-1:0]         com_valid;
    logic [CW-1:0][6:0]    com_sqn;
    logic                  csr_we;
    logic [4:0]            csr_wdata;
    logic [4:0]            fflags;
    logic                  pending;

    always #5 clk = ~clk;

    fp_flags_buffer #(
        .DEPTH    (64),
        .COMMIT_W (CW),
        .SQN_W    (7)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .IN_branch    (br),
        .IN_upd_valid (upd_valid),
        .IN_upd_sqN   (upd_sqn),
        .IN_upd_flags (upd_flags),
        .IN_com_valid (com_valid),
        .IN_com_sqN   (com_sqn),
        .IN_csr_we    (csr_we),
        .IN_csr_wdata (csr_wdata),
        .OUT_fflags   (fflags),
        .OUT_pending  (pending)
    );

    typedef struct {
        logic [4:0] f;
        logic       p;
        int         n;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    logic [4:0] pend[int];
    logic [4:0] m_ff = '0;

    logic               s_br_taken;
    logic [6:0]         s_br_sqn;
    logic               s_upd_valid;
    logic [6:0]         s_upd_sqn;
    logic [4:0]         s_upd_flags;
    logic [CW-1:0]      s_com_valid;
    logic [CW-1:0][6:0] s_com_sqn;
    logic               s_csr_we;
    logic [4:0]         s_csr_wdata;

    function automatic bit newer(input int a, input int b);
        int d;
        d = (((a - b) % 128) + 128) % 128;
        return (d >= 1) && (d <= 63);
    endfunction

    task automatic clear_stage();
        s_br_taken  = 1'b0;
        s_br_sqn    = '0;
        s_upd_valid = 1'b0;
        s_upd_sqn   = '0;
        s_upd_flags = '0;
        s_com_valid = '0;
        s_com_sqn   = '0;
        s_csr_we    = 1'b0;
        s_csr_wdata = '0;
    endtask

    task automatic set_upd(input int sq, input int f);
        s_upd_valid = 1'b1;
        s_upd_sqn   = 7'(sq);
        s_upd_flags = 5'(f);
    endtask

    task automatic set_com(input int slot, input int sq);
        s_com_valid[slot] = 1'b1;
        s_com_sqn[slot]   = 7'(sq);
    endtask

    task automatic set_br(input int sq);
        s_br_taken = 1'b1;
        s_br_sqn   = 7'(sq);
    endtask

    task automatic set_csr(input int d);
        s_csr_we    = 1'b1;
        s_csr_wdata = 5'(d);
    endtask

    // Model: pending results keyed by full sqN; an entry slot is sqN mod 64.
    task automatic model_step();
        logic [4:0] acc;
        int         kill[$];
        acc = '0;
        for (int i = 0; i < CW; i++) begin
            if (s_com_valid[i] && pend.exists(int'(s_com_sqn[i]))) begin
                acc = acc | pend[int'(s_com_sqn[i])];
                pend.delete(int'(s_com_sqn[i]));
            end
        end
        if (s_br_taken) begin
            foreach (pend[k]) if (newer(k, int'(s_br_sqn))) kill.push_back(k);
        end
        if (s_upd_valid && !(s_br_taken && newer(int'(s_upd_sqn), int'(s_br_sqn)))) begin
            foreach (pend[k]) if ((k % 64) == (int'(s_upd_sqn) % 64)) kill.push_back(k);
        end
        foreach (kill[j]) if (pend.exists(kill[j])) pend.delete(kill[j]);
        if (s_upd_valid && !(s_br_taken && newer(int'(s_upd_sqn), int'(s_br_sqn))))
            pend[int'(s_upd_sqn)] = s_upd_flags;
        m_ff = (s_csr_we ? s_csr_wdata : m_ff) | acc;
    endtask

    task automatic drive_idle();
        br        = '0;
        upd_valid = 1'b0;
        upd_sqn   = '0;
        upd_flags = '0;
        com_valid = '0;
        com_sqn   = '0;
        csr_we    = 1'b0;
        csr_wdata = '0;
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        #1;
        rst       = 1'b1;
        br        = '{taken: s_br_taken, sqN: s_br_sqn};
        upd_valid = s_upd_valid;
        upd_sqn   = s_upd_sqn;
        upd_flags = s_upd_flags;
        com_valid = s_com_valid;
        com_sqn   = s_com_sqn;
        csr_we    = s_csr_we;
        csr_wdata = s_csr_wdata;
        model_step();
        e.f = m_ff;
        e.p = (pend.num() != 0);
        e.n = cyc;
        sb.push_back(e);
        cyc++;
        clear_stage();
    endtask

    task automatic check_now(input string name, input logic [4:0] ef, input logic ep);
        checks++;
        if (fflags !== ef) begin
            errors++;
            $display("FAIL %s fflags: got %b expected %b", name, fflags, ef);
        end
        checks++;
        if (pending !== ep) begin
            errors++;
            $display("FAIL %s pending: got %b expected %b", name, pending, ep);
        end
    endtask

    task automatic reset_mid();
        exp_t e;
        @(negedge clk);
        #1;
        drive_idle();
        #2;
        rst = 1'b0;
        #1;
        check_now("async_reset", 5'b00000, 1'b0);
        pend.delete();
        m_ff = '0;
        e.f = '0;
        e.p = 1'b0;
        e.n = cyc;
        sb.push_back(e);
        cyc++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (fflags !== e.f) begin
                    errors++;
                    $display("FAIL sb_fflags cycle %0d: got %b expected %b", e.n, fflags, e.f);
                end
                checks++;
                if (pending !== e.p) begin
                    errors++;
                    $display("FAIL sb_pending cycle %0d: got %b expected %b", e.n, pending, e.p);
                end
            end
        end
    end

    initial begin : driver
        int base;
        int c;
        bit ok;
        drive_idle();
        clear_stage();
        #3;
        check_now("reset_state", 5'b00000, 1'b0);

        // Basic accumulation
        set_upd(5, 5'b00001); cycle();
        set_upd(6, 5'b10000); cycle();
        set_com(0, 5); set_com(1, 6); cycle();
        cycle();
        check_now("basic_acc", 5'b10001, 1'b0);

        // Flush, with a dropped same-cycle younger update
        set_csr(0); cycle();
        set_upd(10, 5'b00001); cycle();
        set_upd(11, 5'b00100); cycle();
        set_upd(12, 5'b01000); cycle();
        set_br(11); set_upd(13, 5'b10000); cycle();
        set_com(0, 10); set_com(1, 11); set_com(2, 12); set_com(3, 13); cycle();
        cycle();
        check_now("flush", 5'b00101, 1'b0);

        // CSR write colliding with a commit
        set_csr(5'b11111); set_upd(30, 5'b00010); cycle();
        set_csr(0); set_com(0, 30); cycle();
        cycle();
        check_now("csr_commit", 5'b00010, 1'b0);

        // Wrap-around tag mismatch
        set_csr(0); set_upd(3, 5'b10000); cycle();
        set_upd(67, 5'b00001); cycle();
        set_com(0, 3); cycle();
        cycle();
        check_now("wrap_stale", 5'b00000, 1'b1);
        set_com(0, 67); cycle();
        cycle();
        check_now("wrap_new", 5'b00001, 1'b0);

        // Full commit width, then a non-FP commit
        set_csr(0); set_upd(20, 1); cycle();
        set_upd(21, 2); cycle();
        set_upd(22, 4); cycle();
        set_upd(23, 8); cycle();
        set_com(0, 20); set_com(1, 21); set_com(2, 22); set_com(3, 23); cycle();
        set_com(2, 40); cycle();
        cycle();
        check_now("full_width", 5'b01111, 1'b0);

        // Reset mid-operation
        set_csr(0); cycle();
        set_upd(50, 1); cycle();
        set_upd(51, 2); cycle();
        set_upd(52, 4); cycle();
        set_com(0, 50); cycle();
        cycle();
        check_now("pre_reset", 5'b00001, 1'b1);
        reset_mid();
        set_com(0, 51); set_com(1, 52); cycle();
        cycle();
        check_now("post_reset", 5'b00000, 1'b0);

        // Random traffic in a sliding sqN window that wraps several times
        base = 0;
        for (int n = 0; n < 1500; n++) begin
            if (n % 4 == 0) base = (base + 1) % 128;
            if ($urandom_range(0, 1) == 1)
                set_upd((base + int'($urandom_range(0, 15))) % 128,
                        ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31)));
            if ($urandom_range(0, 9) == 0)
                set_br((base + int'($urandom_range(0, 15))) % 128);
            for (int s = 0; s < CW; s++) begin
                if ($urandom_range(0, 1) == 1) begin
                    c  = (base + int'($urandom_range(0, 15))) % 128;
                    ok = 1'b1;
                    if (s_upd_valid && (int'(s_upd_sqn) == c)) ok = 1'b0;
                    if (s_br_taken && newer(c, int'(s_br_sqn))) ok = 1'b0;
                    for (int p = 0; p < s; p++)
                        if (s_com_valid[p] && (int'(s_com_sqn[p]) == c)) ok = 1'b0;
                    if (ok) set_com(s, c);
                end
            end
            if ($urandom_range(0, 7) == 0) set_csr(int'($urandom_range(0, 31)));
            cycle();
        end

        cycle();
        cycle();
        @(negedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expectations required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
